// File: rtl/pool_engine.sv
// 2-D max/average pooling engine: walks CHANNELS x OUT_DIM x OUT_DIM windows in the shared BRAM.
// Latency: WIN*WIN + RD_LAT + 1 cycles per window; done pulses one cycle after the final write.
// No backpressure: the BRAM is owned for the whole run; start is ignored while busy.
// Optional feature macro: POOL_RELU_EN (clamp negative results to zero before writing).
module pool_engine #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 15,
  parameter int CHANNELS = 50,
  parameter int IN_DIM   = 8,
  parameter int WIN      = 2,
  parameter int STRIDE   = 2,
  parameter int RD_LAT   = 2,
  parameter int SRC_BASE = 14400,
  parameter int DST_BASE = 17600
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic              bram_ena,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dina,
  input  logic [DATA_W-1:0] bram_douta
);

  localparam int OUT_DIM = (IN_DIM - WIN) / STRIDE + 1;
  localparam int K       = WIN * WIN;
  localparam int SHIFT   = 2 * $clog2(WIN);
  localparam int SUM_W   = DATA_W + SHIFT;
  localparam int CH_W    = $clog2(CHANNELS + 1);
  localparam int OD_W    = $clog2(OUT_DIM + 1);
  localparam int KI_W    = $clog2(K + 1);

  if (WIN < 1 || (WIN & (WIN - 1)) != 0) begin : g_bad_win
    $error("pool_engine: WIN must be a power of two >= 1");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("pool_engine: RD_LAT must be in 1..4");
  end

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_WRITE, S_FIN} state_t;

  state_t                    state_q, state_d;
  logic                      mode_q, mode_d;
  logic [CH_W-1:0]           ch_q, ch_d, nc;
  logic [OD_W-1:0]           row_q, row_d, nr;
  logic [OD_W-1:0]           col_q, col_d, nx;
  logic [KI_W-1:0]           rd_idx_q, rd_idx_d;
  logic [KI_W-1:0]           cap_q, cap_d;
  logic signed [SUM_W-1:0]   acc_q, acc_d, acc_nxt, samp;
  logic [RD_LAT-1:0]         vld_q, vld_d;
  logic                      busy_q, busy_d, done_q, done_d;
  logic                      ena_q, ena_d, wea_q, wea_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [DATA_W-1:0]         dina_q, dina_d, res;
  logic                      tag_out, last_cap;

  // Source address of sample idx (row-major inside the window) of window (c, r, x).
  function automatic logic [ADDR_W-1:0] src_addr(input logic [CH_W-1:0] c,
                                                 input logic [OD_W-1:0] r,
                                                 input logic [OD_W-1:0] x,
                                                 input logic [KI_W-1:0] idx);
    int wi, wj, a;
    wi = int'(idx) / WIN;
    wj = int'(idx) % WIN;
    a  = SRC_BASE + int'(c) * IN_DIM * IN_DIM + (int'(r) * STRIDE + wi) * IN_DIM
         + int'(x) * STRIDE + wj;
    return ADDR_W'(a);
  endfunction

  // Destination address of the result of window (c, r, x).
  function automatic logic [ADDR_W-1:0] dst_addr(input logic [CH_W-1:0] c,
                                                 input logic [OD_W-1:0] r,
                                                 input logic [OD_W-1:0] x);
    int a;
    a = DST_BASE + int'(c) * OUT_DIM * OUT_DIM + int'(r) * OUT_DIM + int'(x);
    return ADDR_W'(a);
  endfunction

  assign busy       = busy_q;
  assign done       = done_q;
  assign bram_ena   = ena_q;
  assign bram_wea   = wea_q;
  assign bram_addra = addr_q;
  assign bram_dina  = dina_q;

  assign tag_out  = vld_q[RD_LAT-1];
  assign last_cap = tag_out && (cap_q == KI_W'(K - 1));

  // Next-state, reducer and registered BRAM-port logic; outputs are computed one cycle ahead.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    ch_d     = ch_q;
    row_d    = row_q;
    col_d    = col_q;
    rd_idx_d = rd_idx_q;
    cap_d    = cap_q;
    acc_d    = acc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ena_d    = 1'b0;
    wea_d    = 1'b0;
    addr_d   = addr_q;
    dina_d   = dina_q;

    // Each issued read is tagged; the tag reaches the end when its data is on bram_douta.
    vld_d = (vld_q << 1) | RD_LAT'(state_q == S_READ);

    // Reducer: first sample seeds the accumulator, later ones fold in by max or sum.
    samp = SUM_W'(signed'(bram_douta));
    if (cap_q == '0)
      acc_nxt = samp;
    else if (mode_q)
      acc_nxt = acc_q + samp;
    else
      acc_nxt = (samp > acc_q) ? samp : acc_q;

    res = mode_q ? DATA_W'(acc_nxt >>> SHIFT) : DATA_W'(acc_nxt);
`ifdef POOL_RELU_EN
    if (res[DATA_W-1]) res = '0;
`endif

    if (tag_out) begin
      acc_d = acc_nxt;
      cap_d = last_cap ? '0 : cap_q + 1'b1;
    end

    // Window counter advance: col wraps into row, row wraps into channel.
    nc = ch_q;
    nr = row_q;
    nx = col_q;
    if (col_q == OD_W'(OUT_DIM - 1)) begin
      nx = '0;
      if (row_q == OD_W'(OUT_DIM - 1)) begin
        nr = '0;
        nc = ch_q + 1'b1;
      end else begin
        nr = row_q + 1'b1;
      end
    end else begin
      nx = col_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d   = mode;
          ch_d     = '0;
          row_d    = '0;
          col_d    = '0;
          rd_idx_d = '0;
          cap_d    = '0;
          busy_d   = 1'b1;
          ena_d    = 1'b1;
          addr_d   = src_addr('0, '0, '0, '0);
          state_d  = S_READ;
        end
      end
      S_READ: begin
        if (rd_idx_q == KI_W'(K - 1)) begin
          state_d = S_DRAIN;
        end else begin
          ena_d    = 1'b1;
          rd_idx_d = rd_idx_q + 1'b1;
          addr_d   = src_addr(ch_q, row_q, col_q, rd_idx_q + 1'b1);
        end
      end
      S_DRAIN: begin
        if (last_cap) begin
          ena_d   = 1'b1;
          wea_d   = 1'b1;
          addr_d  = dst_addr(ch_q, row_q, col_q);
          dina_d  = res;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        ch_d  = nc;
        row_d = nr;
        col_d = nx;
        if (nc == CH_W'(CHANNELS)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          ena_d    = 1'b1;
          rd_idx_d = '0;
          addr_d   = src_addr(nc, nr, nx, '0);
          state_d  = S_READ;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters, reducer and output registers; reset aborts any run immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      ch_q     <= '0;
      row_q    <= '0;
      col_q    <= '0;
      rd_idx_q <= '0;
      cap_q    <= '0;
      acc_q    <= '0;
      vld_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ena_q    <= 1'b0;
      wea_q    <= 1'b0;
      addr_q   <= '0;
      dina_q   <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      ch_q     <= ch_d;
      row_q    <= row_d;
      col_q    <= col_d;
      rd_idx_q <= rd_idx_d;
      cap_q    <= cap_d;
      acc_q    <= acc_d;
      vld_q    <= vld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ena_q    <= ena_d;
      wea_q    <= wea_d;
      addr_q   <= addr_d;
      dina_q   <= dina_d;
    end
  end

endmodule

// File: tb/tb_pool_engine.sv
// Bench for pool_engine: default-size instance (RD_LAT=2) plus a small stride-1 instance (RD_LAT=1).
// Expected results come from a window-level model over the bench's BRAM image.
// BRAM models honour each instance's read latency; writes are logged with their cycle.
module tb_pool_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, mode = 1'b0;
  logic        busy, done, ena, wea;
  logic [14:0] addr;
  logic [7:0]  dina;
  logic [7:0]  dout;
  logic [7:0]  p0;

  logic        start_s = 1'b0, mode_s = 1'b0;
  logic        busy_s, done_s, ena_s, wea_s;
  logic [14:0] addr_s;
  logic [7:0]  dina_s;
  logic [7:0]  dout_s;

  logic [7:0]  in_mem [0:32767];

  int cyc = 0;
  int passed = 0;
  int failed = 0;
  int total = 0;

  int wa[$], wd[$], wc[$], dq[$], dbusy[$];
  int sa[$], sd[$], sc[$], sdq[$];

  pool_engine u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy), .done(done),
    .bram_ena(ena), .bram_wea(wea), .bram_addra(addr), .bram_dina(dina), .bram_douta(dout)
  );

  pool_engine #(.CHANNELS(2), .IN_DIM(4), .WIN(2), .STRIDE(1), .RD_LAT(1)) u_small (
    .clk(clk), .rst(rst), .start(start_s), .mode(mode_s), .busy(busy_s), .done(done_s),
    .bram_ena(ena_s), .bram_wea(wea_s), .bram_addra(addr_s), .bram_dina(dina_s),
    .bram_douta(dout_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM read paths: two-stage for the default instance, one-stage for the small one.
  always @(posedge clk) begin
    if (ena && !wea) p0 <= in_mem[addr];
    dout <= p0;
    if (ena_s && !wea_s) dout_s <= in_mem[addr_s];
  end

  // Write / done logger, sampled mid-cycle.
  always @(negedge clk) begin
    if (ena && wea) begin
      wa.push_back(int'(addr)); wd.push_back(int'(dina)); wc.push_back(cyc);
    end
    if (done) begin
      dq.push_back(cyc); dbusy.push_back(int'(busy));
    end
    if (ena_s && wea_s) begin
      sa.push_back(int'(addr_s)); sd.push_back(int'(dina_s)); sc.push_back(cyc);
    end
    if (done_s) sdq.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: reduce one 2x2 window straight from the input image.
  function automatic int exp_val(int base, int dim, int stride, int c, int r, int x, bit m);
    int s, mx, v, q, res;
    s  = 0;
    mx = -100000;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        v  = int'($signed(in_mem[base + c*dim*dim + (r*stride + i)*dim + x*stride + j]));
        s  += v;
        if (v > mx) mx = v;
      end
    end
    q = s / 4;
    if (s < 0 && (s % 4) != 0) q = q - 1;
    res = m ? q : mx;
`ifdef POOL_RELU_EN
    if (res < 0) res = 0;
`endif
    return res & 255;
  endfunction

  task automatic fill_random();
    for (int a = 14400; a < 17600; a++) in_mem[a] = 8'($urandom);
  endtask

  // Full default-size run with a stray start at cycle 100, checked window by window.
  task automatic run_big(input bit m, output int wb);
    int db, t0;
    wb = wa.size();
    db = dq.size();
    @(negedge clk); start = 1'b1; mode = m; t0 = cyc;
    @(negedge clk); start = 1'b0; mode = !m;
    check("busy_rise", busy, 1);
    repeat (99) @(negedge clk);
    start = 1'b1;
    check("busy_mid_run", busy, 1);
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 6000 && dq.size() == db; k++) @(negedge clk);
    @(negedge clk);
    check("done_count", dq.size() - db, 1);
    if (dq.size() > db) begin
      check("done_cycle", dq[db] - t0, 5601);
      check("busy_at_done", dbusy[db], 0);
    end
    check("write_count", wa.size() - wb, 800);
    for (int n = 0; n < 800 && wb + n < wa.size(); n++) begin
      check("wr_addr", wa[wb+n], 17600 + n);
      check("wr_data", wd[wb+n], exp_val(14400, 8, 2, n/16, (n%16)/4, n%4, m));
      check("wr_cycle", wc[wb+n] - t0, (n + 1) * 7);
    end
  endtask

  initial begin
    int wb, db, sb, sdb, t0;
    bit ms;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ena", ena, 0);
    check("rst_wea", wea, 0);
    check("rst_addr", addr, 0);
    check("rst_dina", dina, 0);
    check("rst_small_ena", ena_s, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Max mode, channel 0 = 0..63
    fill_random();
    for (int a = 0; a < 64; a++) in_mem[14400 + a] = 8'(a);
    run_big(1'b0, wb);
    check("max_w0", wd[wb], 9);
    check("max_w1", wd[wb+1], 11);
    check("max_w4", wd[wb+4], 25);
    check("max_w15", wd[wb+15], 63);

    // Small stride-1 instance, start held high through done
    ms = 1'($urandom_range(0, 1));
    sb = sa.size(); sdb = sdq.size();
    @(negedge clk); start_s = 1'b1; mode_s = ms; t0 = cyc;
    for (int k = 1; k <= 111; k++) begin
      @(negedge clk);
      if (k == 110) check("s_idle_after_done", busy_s, 0);
    end
    check("s_restart_busy", busy_s, 1);
    start_s = 1'b0;
    for (int k = 0; k < 300 && sdq.size() < sdb + 2; k++) @(negedge clk);
    @(negedge clk);
    check("s_done_count", sdq.size() - sdb, 2);
    if (sdq.size() > sdb) check("s_done_cycle", sdq[sdb] - t0, 109);
    check("s_write_count", sa.size() - sb, 36);
    for (int n = 0; n < 36 && sb + n < sa.size(); n++) begin
      check("s_wr_addr", sa[sb+n], 17600 + (n % 18));
      check("s_wr_data", sd[sb+n], exp_val(14400, 4, 1, (n%18)/9, (n%9)/3, n%3, ms));
      check("s_wr_cycle", sc[sb+n] - t0, (n < 18) ? (n + 1) * 6 : 110 + (n - 17) * 6);
    end

    // Average mode with the rounding windows placed in channel 0
    fill_random();
    in_mem[14400] = 8'hFD; in_mem[14401] = 8'hFE; in_mem[14408] = 8'h05; in_mem[14409] = 8'h07;
    in_mem[14402] = 8'hFD; in_mem[14403] = 8'hFE; in_mem[14410] = 8'hFF; in_mem[14411] = 8'h01;
    run_big(1'b1, wb);
    check("avg_pos", wd[wb], 1);
`ifdef POOL_RELU_EN
    check("avg_neg", wd[wb+1], 0);
`else
    check("avg_neg", wd[wb+1], 8'hFE);
`endif

    // Reset asserted during READ at cycle 50
    wb = wa.size(); db = dq.size();
    @(negedge clk); start = 1'b1; mode = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (49) @(negedge clk);
    check("pre_rst_ena", ena, 1);
    check("pre_rst_wea", wea, 0);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_ena", ena, 0);
    check("mid_rst_wea", wea, 0);
    check("mid_rst_addr", addr, 0);
    check("mid_rst_dina", dina, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_write_count", wa.size() - wb, 7);
    check("rst_no_done", dq.size() - db, 0);
    check("rst_idle_busy", busy, 0);
    run_big(1'b0, wb);

    // All samples at the most negative value
    for (int a = 14400; a < 17600; a++) in_mem[a] = 8'h80;
    run_big(1'b0, wb);
`ifdef POOL_RELU_EN
    check("min_val", wd[wb], 0);
`else
    check("min_val", wd[wb], 8'h80);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pool_engine.md
# pool_engine

Parametrised 2-D pooling engine for the LeNet accelerator; next generation of the fixed 2×2/stride-2 pooling stage. It walks every channel of a feature map stored in the shared result BRAM, reads each pooling window, and reduces it by max or average (runtime-selected). It writes one result per window back to the same BRAM. Window reads are pipelined against the BRAM read latency instead of being serialised with idle cycles.

## Interface
- DATA_W, 8: signed two's-complement sample width.
- ADDR_W, 15: BRAM address width.
- CHANNELS, 50: feature-map channels processed per run.
- IN_DIM, 8: input map height = width.
- WIN, 2: window height = width; must be a power of two ≥1 (elaboration error otherwise).
- STRIDE, 2: window step; OUT_DIM = (IN_DIM−WIN)/STRIDE+1.
- RD_LAT, 2: BRAM read latency in cycles, 1..4.
- SRC_BASE, 14400: address of channel 0, pixel (0,0) of the input map.
- DST_BASE, 17600: address of channel 0, pixel (0,0) of the output map.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle run request; sampled only in IDLE.
- mode  in  1  0 = max, 1 = average; latched when start is accepted.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final write.
- bram_ena  out  1  BRAM enable.
- bram_wea  out  1  BRAM write enable.
- bram_addra  out  ADDR_W  BRAM address.
- bram_dina  out  DATA_W  BRAM write data.
- bram_douta  in  DATA_W  BRAM read data, valid RD_LAT cycles after the address.

## Operation
- States: IDLE → READ → DRAIN → WRITE → (READ | FIN) → IDLE.
- IDLE: on start=1, latch mode, clear the channel/row/col counters, go to READ. Start is ignored while busy.
- READ: issue K=WIN·WIN reads, one per cycle, bram_ena=1, bram_wea=0, in window row-major order (i,j).
  - Read address = SRC_BASE + c·IN_DIM² + (r·STRIDE+i)·IN_DIM + (col·STRIDE+j).
- A RD_LAT-deep valid shift register tags each read. Data is captured into the reducer on the edge where its tag exits the register.
- DRAIN: bram_ena=0; wait for the remaining tags to exit.
- Reducer, max mode: running signed max, initialised with the first sample.
- Reducer, average mode: signed sum of width DATA_W+2·log2(WIN), then an arithmetic right shift by 2·log2(WIN) (floor), then truncation to DATA_W. The result always fits.
- WRITE: one cycle with bram_ena=1, bram_wea=1, bram_dina=result.
  - Write address = DST_BASE + c·OUT_DIM² + r·OUT_DIM + col.
- Counter advance: col wraps at OUT_DIM into r; r wraps at OUT_DIM into c. When c reaches CHANNELS, go to FIN; otherwise go to READ.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- The address arithmetic must not overflow ADDR_W. This is an integrator responsibility and is not checked.

## Timing
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, bram_ena=0, bram_wea=0, bram_addra=0, bram_dina=0; counters and the valid pipeline cleared.
- Reset mid-run aborts immediately. No write completes after reset asserts, and no done pulse is produced.
- Cycle 0: start accepted. Cycles 1..K: read addresses. The last sample is captured at cycle K+RD_LAT. Cycle K+RD_LAT+1: write.
- Per window: K+RD_LAT+1 cycles. The next window's first read is in the cycle after the write.
- Total run: CHANNELS·OUT_DIM²·(K+RD_LAT+1) cycles. Done follows in the next cycle.
- Defaults: 50·16·7 = 5600 cycles, so done is at cycle 5601.
- busy rises at cycle 1 and falls together with the done pulse.
- start asserted in the same cycle as done is ignored. It is accepted in the following IDLE cycle if still high.
- bram_addra holds its last value when bram_ena=0.

## Configuration
- POOL_RELU_EN defined: the reduced result is clamped at 0 before writing (negative → 0), in both modes.
- POOL_RELU_EN undefined: the result is written unmodified, including negative values.

## Test plan
- Defaults, max mode, BRAM model RD_LAT=2, channel 0 input = 0..63:
  - Output at 17600..17615 = 9, 11, 13, 15, 25, …, 63.
  - done at cycle 5601.
- Avg mode, window {−3, −2, 5, 7}: sum 7 → 7>>>2 = 1 written.
  - Window {−3, −2, −1, 1}: −5>>>2 = −2 written without POOL_RELU_EN, 0 with it.
- WIN=2, STRIDE=1, IN_DIM=4, CHANNELS=2, RD_LAT=1:
  - 9 writes per channel to DST_BASE+0..17.
  - Each write one cycle after the window's 4th read plus 1.
- Start pulsed again at cycle 100 of a run: ignored; busy stays 1; exactly one done pulse.
- rst driven low at cycle 50 during READ:
  - All outputs go to 0 within the same cycle.
  - No done pulse.
  - A fresh start afterwards reproduces the full run's expected outputs.
- Max mode, all samples −128 (0x80): every output is 0x80, or 0x00 with POOL_RELU_EN.
